// File: rtl/soft_bit_posterior.sv
// Per-bit posterior stage of the VT-code IDS decoder: scans alpha[t-1] and beta[t]
// over all drift/syndrome states and emits a max-log LLR, hard decision and erasure flag.
module soft_bit_posterior #(
    parameter int DATA_WIDTH = 32,
    parameter int n          = 10,
    parameter int J          = 2*n+1,
    parameter int M          = n+1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [$clog2(n+1)-1:0]        rd_t,
    output logic [$clog2(J)-1:0]          rd_j,
    output logic [$clog2(M)-1:0]          rd_s0,
    output logic [$clog2(M)-1:0]          rd_s1,
    output logic                          rd_en,
    input  logic signed [DATA_WIDTH-1:0]  alpha_rd_data,
    input  logic signed [DATA_WIDTH-1:0]  beta0_rd_data,
    input  logic signed [DATA_WIDTH-1:0]  beta1_rd_data,
    output logic                          llr_valid,
    input  logic                          llr_ready,
    output logic [$clog2(n+1)-1:0]        llr_pos,
    output logic signed [DATA_WIDTH-1:0]  llr,
    output logic                          hard_bit,
    output logic                          erasure,
    output logic                          busy,
    output logic                          done
);

    localparam int TW = $clog2(n+1);
    localparam int JW = $clog2(J);
    localparam int SW = $clog2(M);

    localparam logic signed [DATA_WIDTH-1:0] NEG_INF  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] POS_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] NEG_MAX  = {1'b1, {(DATA_WIDTH-2){1'b0}}, 1'b1};
    localparam logic signed [DATA_WIDTH:0]   WIDE_MAX = {2'b00, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH:0]   WIDE_MIN = {2'b11, {(DATA_WIDTH-2){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, SCAN, FLUSH, EMIT, FINISH} state_t;

    // The clamp keeps NEG_INF reserved exclusively for "-inf".
    function automatic logic signed [DATA_WIDTH-1:0] clamp_wide(input logic signed [DATA_WIDTH:0] v);
        if (v > WIDE_MAX) begin
            clamp_wide = POS_MAX;
        end else if (v < WIDE_MIN) begin
            clamp_wide = NEG_MAX;
        end else begin
            clamp_wide = v[DATA_WIDTH-1:0];
        end
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat_add(input logic signed [DATA_WIDTH-1:0] a,
                                                             input logic signed [DATA_WIDTH-1:0] b);
        if (a == NEG_INF || b == NEG_INF) begin
            sat_add = NEG_INF;
        end else begin
            sat_add = clamp_wide({a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b});
        end
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] llr_of(input logic signed [DATA_WIDTH-1:0] l0,
                                                            input logic signed [DATA_WIDTH-1:0] l1);
        if (l0 == NEG_INF && l1 == NEG_INF) begin
            llr_of = {DATA_WIDTH{1'b0}};
        end else if (l1 == NEG_INF) begin
            llr_of = POS_MAX;
        end else if (l0 == NEG_INF) begin
            llr_of = NEG_MAX;
        end else begin
            llr_of = clamp_wide({l0[DATA_WIDTH-1], l0} - {l1[DATA_WIDTH-1], l1});
        end
    endfunction

    // s and t are both below M, so one conditional subtraction gives the modulus.
    function automatic logic [SW-1:0] s1_of(input int s, input int t);
        int v;
        v = s + t;
        if (v >= M) begin
            v = v - M;
        end else begin
            v = v;
        end
        s1_of = SW'(v);
    endfunction

    state_t                        state_r, state_nxt_s;
    logic                          acc_en_r;
    logic signed [DATA_WIDTH-1:0]  l0_r, l1_r, l0_nxt_s, l1_nxt_s;
    logic signed [DATA_WIDTH-1:0]  sum0_s, sum1_s, l0_acc_s, l1_acc_s;
    logic [TW-1:0]                 rd_t_nxt_s, llr_pos_nxt_s;
    logic [JW-1:0]                 rd_j_nxt_s;
    logic [SW-1:0]                 rd_s0_nxt_s, rd_s1_nxt_s;
    logic                          rd_en_nxt_s, llr_valid_nxt_s, hard_nxt_s, erasure_nxt_s;
    logic                          busy_nxt_s, done_nxt_s;
    logic signed [DATA_WIDTH-1:0]  llr_nxt_s;

    // Max-log accumulation of the read data returned this cycle.
    always_comb begin
        sum0_s   = sat_add(alpha_rd_data, beta0_rd_data);
        sum1_s   = sat_add(alpha_rd_data, beta1_rd_data);
        l0_acc_s = l0_r;
        l1_acc_s = l1_r;
        if (acc_en_r && (sum0_s > l0_r)) begin
            l0_acc_s = sum0_s;
        end else begin
            l0_acc_s = l0_r;
        end
        if (acc_en_r && (sum1_s > l1_r)) begin
            l1_acc_s = sum1_s;
        end else begin
            l1_acc_s = l1_r;
        end
    end

    // Next-state, read-address and result decode.
    always_comb begin
        state_nxt_s     = state_r;
        rd_t_nxt_s      = rd_t;
        rd_j_nxt_s      = rd_j;
        rd_s0_nxt_s     = rd_s0;
        rd_s1_nxt_s     = rd_s1;
        rd_en_nxt_s     = 1'b0;
        llr_valid_nxt_s = llr_valid;
        llr_pos_nxt_s   = llr_pos;
        llr_nxt_s       = llr;
        hard_nxt_s      = hard_bit;
        erasure_nxt_s   = erasure;
        busy_nxt_s      = busy;
        done_nxt_s      = 1'b0;
        l0_nxt_s        = l0_acc_s;
        l1_nxt_s        = l1_acc_s;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SCAN;
                    rd_t_nxt_s  = TW'(1);
                    rd_j_nxt_s  = {JW{1'b0}};
                    rd_s0_nxt_s = {SW{1'b0}};
                    rd_s1_nxt_s = s1_of(0, 1);
                    rd_en_nxt_s = 1'b1;
                    busy_nxt_s  = 1'b1;
                    l0_nxt_s    = NEG_INF;
                    l1_nxt_s    = NEG_INF;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (rd_s0 == SW'(M-1)) begin
                    if (rd_j == JW'(J-1)) begin
                        state_nxt_s = FLUSH;
                    end else begin
                        rd_en_nxt_s = 1'b1;
                        rd_j_nxt_s  = rd_j + JW'(1);
                        rd_s0_nxt_s = {SW{1'b0}};
                        rd_s1_nxt_s = s1_of(0, int'(rd_t));
                    end
                end else begin
                    rd_en_nxt_s = 1'b1;
                    rd_s0_nxt_s = rd_s0 + SW'(1);
                    rd_s1_nxt_s = s1_of(int'(rd_s0) + 1, int'(rd_t));
                end
            end
            FLUSH: begin
                state_nxt_s     = EMIT;
                llr_valid_nxt_s = 1'b1;
                llr_pos_nxt_s   = rd_t;
                llr_nxt_s       = llr_of(l0_acc_s, l1_acc_s);
                hard_nxt_s      = (l1_acc_s > l0_acc_s);
                erasure_nxt_s   = (l0_acc_s == NEG_INF) && (l1_acc_s == NEG_INF);
            end
            EMIT: begin
                if (llr_ready) begin
                    llr_valid_nxt_s = 1'b0;
                    if (rd_t == TW'(n)) begin
                        state_nxt_s = FINISH;
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = SCAN;
                        rd_t_nxt_s  = rd_t + TW'(1);
                        rd_j_nxt_s  = {JW{1'b0}};
                        rd_s0_nxt_s = {SW{1'b0}};
                        rd_s1_nxt_s = s1_of(0, int'(rd_t) + 1);
                        rd_en_nxt_s = 1'b1;
                        l0_nxt_s    = NEG_INF;
                        l1_nxt_s    = NEG_INF;
                    end
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            FINISH: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, accumulator and registered output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            acc_en_r  <= 1'b0;
            l0_r      <= NEG_INF;
            l1_r      <= NEG_INF;
            rd_t      <= {TW{1'b0}};
            rd_j      <= {JW{1'b0}};
            rd_s0     <= {SW{1'b0}};
            rd_s1     <= {SW{1'b0}};
            rd_en     <= 1'b0;
            llr_valid <= 1'b0;
            llr_pos   <= {TW{1'b0}};
            llr       <= {DATA_WIDTH{1'b0}};
            hard_bit  <= 1'b0;
            erasure   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            acc_en_r  <= rd_en;
            l0_r      <= l0_nxt_s;
            l1_r      <= l1_nxt_s;
            rd_t      <= rd_t_nxt_s;
            rd_j      <= rd_j_nxt_s;
            rd_s0     <= rd_s0_nxt_s;
            rd_s1     <= rd_s1_nxt_s;
            rd_en     <= rd_en_nxt_s;
            llr_valid <= llr_valid_nxt_s;
            llr_pos   <= llr_pos_nxt_s;
            llr       <= llr_nxt_s;
            hard_bit  <= hard_nxt_s;
            erasure   <= erasure_nxt_s;
            busy      <= busy_nxt_s;
            done      <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_soft_bit_posterior.sv
// Directed bench for soft_bit_posterior at n=2, J=5, M=3 with a behavioural
// one-cycle-latency metric memory.
module tb_soft_bit_posterior;

    localparam int NP = 2;
    localparam int JP = 5;
    localparam int MP = 3;
    localparam logic signed [31:0] NEG  = 32'sh8000_0000;
    localparam logic signed [31:0] PMAX = 32'sh7fff_ffff;
    localparam logic signed [31:0] NMAX = 32'sh8000_0001;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [1:0]         rd_t;
    logic [2:0]         rd_j;
    logic [1:0]         rd_s0, rd_s1;
    logic               rd_en;
    logic signed [31:0] alpha_rd_data, beta0_rd_data, beta1_rd_data;
    logic               llr_valid, llr_ready;
    logic [1:0]         llr_pos;
    logic signed [31:0] llr;
    logic               hard_bit, erasure, busy, done;

    logic signed [31:0] a_mem  [0:2][0:4][0:2];
    logic signed [31:0] b0_mem [0:2][0:4][0:2];
    logic signed [31:0] b1_mem [0:2][0:4][0:2];

    int pass_cnt = 0;
    int total_cnt = 0;
    int s1_err = 0;

    int                 n_got, done_cnt, done_idx;
    int                 got_idx  [0:1];
    logic [1:0]         got_pos  [0:1];
    logic signed [31:0] got_llr  [0:1];
    logic               got_hard [0:1];
    logic               got_er   [0:1];

    soft_bit_posterior #(.DATA_WIDTH(32), .n(NP), .J(JP), .M(MP)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rd_t(rd_t), .rd_j(rd_j), .rd_s0(rd_s0), .rd_s1(rd_s1), .rd_en(rd_en),
        .alpha_rd_data(alpha_rd_data), .beta0_rd_data(beta0_rd_data), .beta1_rd_data(beta1_rd_data),
        .llr_valid(llr_valid), .llr_ready(llr_ready), .llr_pos(llr_pos), .llr(llr),
        .hard_bit(hard_bit), .erasure(erasure), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Metric memory: data for a strobed read appears one cycle later; beta1 uses the bench's own s1.
    always @(posedge clk) begin
        if (rd_en) begin
            int t, j, s, s1;
            t  = int'(rd_t);
            j  = int'(rd_j);
            s  = int'(rd_s0);
            s1 = (s + t) % MP;
            if (int'(rd_s1) != s1) s1_err++;
            if (t >= 1 && t <= NP && j < JP && s < MP) begin
                alpha_rd_data <= a_mem[t-1][j][s];
                beta0_rd_data <= b0_mem[t][j][s];
                beta1_rd_data <= b1_mem[t][j][s1];
            end else begin
                alpha_rd_data <= NEG;
                beta0_rd_data <= NEG;
                beta1_rd_data <= NEG;
            end
        end
    end

    task automatic fill_all(input logic signed [31:0] av, input logic signed [31:0] b0v,
                            input logic signed [31:0] b1v);
        for (int t = 0; t <= NP; t++)
            for (int j = 0; j < JP; j++)
                for (int s = 0; s < MP; s++) begin
                    a_mem[t][j][s]  = av;
                    b0_mem[t][j][s] = b0v;
                    b1_mem[t][j][s] = b1v;
                end
    endtask

    // Pulse start with llr_ready=1 and record results/done by cycle index after the start edge.
    task automatic run_capture();
        n_got = 0; done_cnt = 0; done_idx = -1;
        for (int i = 0; i < 2; i++) begin
            got_idx[i] = -1; got_pos[i] = 2'd0; got_llr[i] = 32'sd0; got_hard[i] = 1'b0; got_er[i] = 1'b0;
        end
        llr_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 120; k++) begin
            if (llr_valid && llr_ready) begin
                if (n_got < 2) begin
                    got_idx[n_got] = k; got_pos[n_got] = llr_pos; got_llr[n_got] = llr;
                    got_hard[n_got] = hard_bit; got_er[n_got] = erasure;
                end
                n_got++;
            end
            if (done) begin
                done_cnt++; done_idx = k;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; llr_ready = 1'b1;
        alpha_rd_data = NEG; beta0_rd_data = NEG; beta1_rd_data = NEG;
        #1;
        total_cnt++;
        if ({rd_en, llr_valid, busy, done, hard_bit, erasure} !== 6'b0) $display("FAIL reset_flags got %b want 000000", {rd_en, llr_valid, busy, done, hard_bit, erasure});
        else pass_cnt++;
        total_cnt++;
        if ({rd_t, rd_j, rd_s0, rd_s1, llr_pos, llr} !== 43'd0) $display("FAIL reset_data got llr=%0d t=%0d pos=%0d want 0", llr, rd_t, llr_pos);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({busy, rd_en, llr_valid} !== 3'b000) $display("FAIL idle_after_reset got %b want 000", {busy, rd_en, llr_valid});
        else pass_cnt++;
    endtask

    task automatic test_uniform();
        fill_all(32'sd0, 32'sd10, 32'sd4);
        run_capture();
        total_cnt++;
        if (n_got !== 2) $display("FAIL uniform_count got %0d want 2", n_got); else pass_cnt++;
        total_cnt++;
        if (got_idx[0] !== JP*MP+1) $display("FAIL uniform_latency got %0d want %0d", got_idx[0] + 1, JP*MP+2); else pass_cnt++;
        total_cnt++;
        if (got_idx[1] !== 2*JP*MP+3) $display("FAIL uniform_second_idx got %0d want %0d", got_idx[1], 2*JP*MP+3); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if ({got_pos[i], got_llr[i], got_hard[i], got_er[i]} !== {2'(i+1), 32'sd6, 1'b0, 1'b0})
                $display("FAIL uniform_result%0d got pos=%0d llr=%0d hb=%b er=%b want pos=%0d llr=6 hb=0 er=0", i, got_pos[i], got_llr[i], got_hard[i], got_er[i], i+1);
            else pass_cnt++;
        end
        total_cnt++;
        if (done_cnt !== 1) $display("FAIL uniform_done_count got %0d want 1", done_cnt); else pass_cnt++;
        total_cnt++;
        if (done_idx !== got_idx[0] + 1 + JP*MP+2) $display("FAIL uniform_done_time got %0d want %0d", done_idx, got_idx[0] + 1 + JP*MP+2); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL uniform_busy_end got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_dominant();
        fill_all(NEG, NEG, NEG);
        a_mem[0][2][1] = 32'sd100;
        b1_mem[1][2][2] = 32'sd50;
        run_capture();
        total_cnt++;
        if ({got_pos[0], got_llr[0], got_hard[0], got_er[0]} !== {2'd1, NMAX, 1'b1, 1'b0})
            $display("FAIL dominant_pos1 got pos=%0d llr=%0d hb=%b er=%b want pos=1 llr=%0d hb=1 er=0", got_pos[0], got_llr[0], got_hard[0], got_er[0], NMAX);
        else pass_cnt++;
        total_cnt++;
        if ({got_pos[1], got_llr[1], got_hard[1], got_er[1]} !== {2'd2, 32'sd0, 1'b0, 1'b1})
            $display("FAIL dominant_pos2 got pos=%0d llr=%0d hb=%b er=%b want pos=2 llr=0 hb=0 er=1", got_pos[1], got_llr[1], got_hard[1], got_er[1]);
        else pass_cnt++;
    endtask

    task automatic test_erasure();
        fill_all(NEG, NEG, NEG);
        run_capture();
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if ({got_pos[i], got_llr[i], got_hard[i], got_er[i]} !== {2'(i+1), 32'sd0, 1'b0, 1'b1})
                $display("FAIL erasure_pos%0d got pos=%0d llr=%0d hb=%b er=%b want llr=0 hb=0 er=1", i+1, got_pos[i], got_llr[i], got_hard[i], got_er[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_saturation();
        fill_all(NEG, NEG, NEG);
        a_mem[0][0][0]  = 32'sh7fff_fffe;
        b0_mem[1][0][0] = 32'sh7fff_fffe;
        // pos2: both sums overflow and must clamp to the same maximum, giving a tie
        a_mem[1][0][0]  = 32'sh7fff_fffe;
        b0_mem[2][0][0] = 32'sh7fff_fffe;
        b1_mem[2][0][2] = 32'sd5;
        run_capture();
        total_cnt++;
        if ({got_llr[0], got_hard[0], got_er[0]} !== {PMAX, 1'b0, 1'b0})
            $display("FAIL sat_pos1 got llr=%0d hb=%b er=%b want llr=%0d hb=0 er=0", got_llr[0], got_hard[0], got_er[0], PMAX);
        else pass_cnt++;
        total_cnt++;
        if ({got_llr[1], got_hard[1], got_er[1]} !== {32'sd0, 1'b0, 1'b0})
            $display("FAIL sat_pos2_tie got llr=%0d hb=%b er=%b want llr=0 hb=0 er=0", got_llr[1], got_hard[1], got_er[1]);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [35:0] snap;
        int w, dcnt;
        logic signed [31:0] llr2;
        fill_all(32'sd0, 32'sd3, 32'sd9);
        llr_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        w = 0;
        while (!llr_valid && w < 100) begin
            @(negedge clk); w++;
        end
        total_cnt++;
        if ({llr_valid, llr_pos, llr, hard_bit, erasure} !== {1'b1, 2'd1, -32'sd6, 1'b1, 1'b0})
            $display("FAIL bp_first got v=%b pos=%0d llr=%0d hb=%b want v=1 pos=1 llr=-6 hb=1", llr_valid, llr_pos, llr, hard_bit);
        else pass_cnt++;
        snap = {llr_pos, llr, hard_bit, erasure};
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            @(negedge clk);
            total_cnt++;
            if ({llr_valid, llr_pos, llr, hard_bit, erasure, rd_en} !== {1'b1, snap, 1'b0})
                $display("FAIL bp_hold cycle %0d got v=%b pos=%0d llr=%0d rd_en=%b want stable and rd_en=0", i, llr_valid, llr_pos, llr, rd_en);
            else pass_cnt++;
        end
        start = 1'b0;
        llr_ready = 1'b1;
        dcnt = 0; llr2 = 32'sd0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (llr_valid && llr_pos == 2'd2) llr2 = llr;
            if (done) dcnt++;
        end
        total_cnt++;
        if ({dcnt, llr2} !== {32'd1, -32'sd6}) $display("FAIL bp_complete got done=%0d llr2=%0d want done=1 llr2=-6", dcnt, llr2);
        else pass_cnt++;
        total_cnt++;
        if ({busy, rd_en} !== 2'b00) $display("FAIL bp_start_ignored got busy=%b rd_en=%b want 00", busy, rd_en);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_scan();
        int w, bad;
        fill_all(32'sd0, 32'sd10, 32'sd4);
        llr_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        w = 0;
        while (!llr_valid && w < 100) begin
            @(negedge clk); w++;
        end
        repeat (5) @(negedge clk);
        total_cnt++;
        if ({busy, rd_en, rd_t} !== {1'b1, 1'b1, 2'd2}) $display("FAIL mid_scan_pos2 got busy=%b rd_en=%b t=%0d want 1 1 2", busy, rd_en, rd_t);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({rd_t, rd_j, rd_s0, rd_s1, rd_en, llr_valid, llr_pos, llr, hard_bit, erasure, busy, done} !== 50'd0)
            $display("FAIL async_reset got busy=%b rd_en=%b t=%0d j=%0d valid=%b want all 0", busy, rd_en, rd_t, rd_j, llr_valid);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || llr_valid || busy) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL reset_no_done got %0d active cycles want 0", bad); else pass_cnt++;
        run_capture();
        total_cnt++;
        if ({n_got, got_pos[0], got_pos[1], got_llr[0], got_llr[1]} !== {32'd2, 2'd1, 2'd2, 32'sd6, 32'sd6})
            $display("FAIL rescan got n=%0d pos=%0d,%0d llr=%0d,%0d want n=2 pos=1,2 llr=6,6", n_got, got_pos[0], got_pos[1], got_llr[0], got_llr[1]);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_uniform();
        test_dominant();
        test_erasure();
        test_saturation();
        test_backpressure();
        test_reset_mid_scan();
        total_cnt++;
        if (s1_err !== 0) $display("FAIL rd_s1_address got %0d wrong reads want 0", s1_err); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/soft_bit_posterior.md
Name: soft_bit_posterior

Overview:
- Downstream consumer of the forward/backward soft recursion stage in the VT-code IDS decoder.
- Once alpha and beta are complete, it scans them position by position.
- For each position it combines alpha at t-1 with beta at t (max-log domain) into a per-bit LLR, hard decision and erasure flag.
- Results stream out over a valid/ready handshake to the final codeword decision logic.

Parameters:
- DATA_WIDTH, 32, width of alpha/beta metrics and of the LLR output.
- n, 10, codeword length before IDS; positions t = 1..n.
- J, 2*n+1, number of drift states per position, indexed j = 0..J-1.
- M, n+1, VT syndrome modulus; syndrome states s = 0..M-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a scan of positions 1..n.
- rd_t  out  $clog2(n+1)  position index for the metric reads. Alpha is read at rd_t-1, beta at rd_t.
- rd_j  out  $clog2(J)  drift index for the reads.
- rd_s0  out  $clog2(M)  syndrome index for the alpha and beta0 reads.
- rd_s1  out  $clog2(M)  syndrome index for the beta1 read, equal to (rd_s0 + rd_t) mod M.
- rd_en  out  1  read strobe; data returns exactly 1 cycle later.
- alpha_rd_data  in  DATA_WIDTH signed  alpha[rd_t-1][rd_j][rd_s0].
- beta0_rd_data  in  DATA_WIDTH signed  beta[rd_t][rd_j][rd_s0].
- beta1_rd_data  in  DATA_WIDTH signed  beta[rd_t][rd_j][rd_s1].
- llr_valid  out  1  result for position llr_pos is presented.
- llr_ready  in  1  consumer accepts the result.
- llr_pos  out  $clog2(n+1)  position t of the presented result.
- llr  out  DATA_WIDTH signed  L0 - L1, saturated.
- hard_bit  out  1  1 if L1 > L0, else 0.
- erasure  out  1  both L0 and L1 are -inf.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after position n is accepted.

Behaviour:
- Reset values (asynchronous, applied immediately): all outputs 0, FSM in IDLE, accumulators at NEG_INF.
- NEG_INF is the most negative DATA_WIDTH value, -2^(DATA_WIDTH-1), and means "-inf".
- FSM states: IDLE, SCAN, FLUSH, EMIT, FINISH.
- IDLE:
  - start=1 -> SCAN with t=1, j=0, s=0, accumulators L0=L1=NEG_INF; busy goes high.
  - start while busy is ignored.
- SCAN:
  - rd_en=1 every cycle; counters step s fastest, then j.
  - After (j=J-1, s=M-1) is issued -> FLUSH.
  - That is J*M read cycles per position (231 at defaults).
- Datapath, one cycle after each read:
  - sum0 = alpha + beta0 and sum1 = alpha + beta1.
  - Sums are computed at DATA_WIDTH+1 bits.
  - If either operand is NEG_INF, the sum is NEG_INF.
  - Otherwise clamp the sum to [-2^(DATA_WIDTH-1)+1, 2^(DATA_WIDTH-1)-1].
  - L0 = max(L0, sum0) and L1 = max(L1, sum1).
- FLUSH: one cycle to absorb the final read data, then -> EMIT.
- EMIT: llr_valid=1 with llr_pos=t.
  - Normal case: llr = clamp(L0 - L1), same clamp range as the sums.
  - If only L1 is NEG_INF: llr = max positive; if only L0 is NEG_INF: llr = -max positive.
  - If both are NEG_INF: llr=0, hard_bit=0, erasure=1.
  - The outputs hold stable while llr_ready=0.
  - On llr_valid & llr_ready with t<n: t+1, j=s=0, L0=L1=NEG_INF, -> SCAN, llr_valid drops the next cycle.
  - On llr_valid & llr_ready with t=n: -> FINISH.
- FINISH: done=1 for one cycle, busy=0, -> IDLE.
- Latency from start to the first llr_valid is J*M+2 cycles.
- Ties (L0 == L1) give hard_bit=0 and llr=0.
- rd_en is 0 outside SCAN. The read address ports hold their last value when rd_en=0.
- rst asserted mid-scan: immediate return to IDLE. No done pulse and no partial result are emitted.

Test Plan:
- n=2, J=5, M=3. All alpha=0; beta0=10, beta1=4 everywhere; llr_ready=1. -> Two results: pos1 then pos2, each llr=6, hard_bit=0, erasure=0. done pulses once, J*M+2 cycles after the second handshake begins.
- Single dominant path: alpha[0][2][1]=100; beta[1][2][2]=50 (reached via s1=(1+1) mod 3); all other entries NEG_INF. -> pos1: L1=150, L0=NEG_INF, llr=-(2^31-1), hard_bit=1.
- All entries NEG_INF. -> llr=0, hard_bit=0, erasure=1 at every position.
- Saturation: alpha=2^31-2 and beta0=2^31-2 at one state, all others NEG_INF. -> sum0 clamps to 2^31-1, L1=NEG_INF, llr=2^31-1.
- Backpressure: hold llr_ready=0 for 20 cycles at pos1. -> llr, llr_pos, hard_bit and erasure stay stable; rd_en stays 0; a start pulse during this wait is ignored.
- Assert rst during SCAN of pos2. -> All outputs 0 immediately, no done pulse. A fresh start then rescans from pos1.
